// File: rtl/spi_master_pkg.sv
// ============================================================================
// Module  : spi_master_pkg
// Brief   : Shared constants, FSM state type, bit-counter type and serial-bit
//           helper for the SPI master (bit order via SPI_MASTER_MSB_FIRST_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_master_pkg;

  localparam int DATA_W = 8;
  localparam int NUM_CS = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  typedef logic [2:0] bitCnt_t;

  // The bit that leaves the word first on the wire.
  function automatic logic serialBit(input logic [DATA_W-1:0] word);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return word[DATA_W-1];
`else
    return word[0];
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
// ============================================================================
// Module  : spi_master_if
// Brief   : Controller-side request/data signals and SPI pins of the master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_if;
  import spi_master_pkg::*;

  logic              start;
  logic [1:0]        slaveSelect;
  logic [DATA_W-1:0] masterDataToSend;
  logic [DATA_W-1:0] masterDataReceived;
  logic              SCLK;
  logic [0:NUM_CS-1] CS;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start, slaveSelect, masterDataToSend, MISO,
    output masterDataReceived, SCLK, CS, MOSI
  );

  modport slave (
    output start, slaveSelect, masterDataToSend, MISO,
    input  masterDataReceived, SCLK, CS, MOSI
  );

endinterface

`default_nettype wire

// File: rtl/spi_shift_reg.sv
// ============================================================================
// Module  : spi_shift_reg
// Brief   : Parallel-load shift register with serial input; shift direction
//           follows SPI_MASTER_MSB_FIRST_EN (LSB first when undefined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_shift_reg
  import spi_master_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] loadData,
  input  wire logic             shiftEn,
  input  wire logic             serialIn,
  output logic      [WIDTH-1:0] nextData
);

  logic [WIDTH-1:0] r_data;

  // Exposing the post-shift value lets the owner act on the bit that
  // arrives on this very edge.
  always_comb begin
`ifdef SPI_MASTER_MSB_FIRST_EN
    nextData = {r_data[WIDTH-2:0], serialIn};
`else
    nextData = {serialIn, r_data[WIDTH-1:1]};
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= loadData;
    end else if (shiftEn) begin
      r_data <= nextData;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module  : spi_master
// Brief   : One-word SPI master, three active-low chip selects, SCLK = ~clk
//           during a transfer. MSB-first option: SPI_MASTER_MSB_FIRST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 3
) (
  input wire logic    clk,
  input wire logic    reset,
  spi_master_if.master bus
);

  localparam logic [1:0] c_MAX_SEL  = 2'(NUM_CS - 1);
  localparam bitCnt_t    c_LAST_BIT = bitCnt_t'(DATA_W - 1);

  state_t            r_state;
  logic              flag;
  bitCnt_t           r_bitCnt;
  logic [0:NUM_CS-1] r_cs;
  logic              r_mosi;
  logic [DATA_W-1:0] r_rxWord;

  logic              w_accept;
  logic              w_shift;
  logic              w_last;
  logic [0:NUM_CS-1] w_csSel;
  logic [DATA_W-1:0] w_txNext;
  logic [DATA_W-1:0] w_rxNext;

  assign w_accept = (r_state == IDLE) && bus.start && (bus.slaveSelect <= c_MAX_SEL);
  assign w_shift  = (r_state == XFER);
  assign w_last   = (r_bitCnt == c_LAST_BIT);

  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_csDecode
    assign w_csSel[gi] = (bus.slaveSelect != 2'(gi));
  end

  spi_shift_reg #(.WIDTH(DATA_W)) u_txShift (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .loadData (bus.masterDataToSend),
    .shiftEn  (w_shift),
    .serialIn (1'b0),
    .nextData (w_txNext)
  );

  spi_shift_reg #(.WIDTH(DATA_W)) u_rxShift (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .loadData ('0),
    .shiftEn  (w_shift),
    .serialIn (bus.MISO),
    .nextData (w_rxNext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      flag     <= 1'b1;
      r_bitCnt <= '0;
      r_cs     <= '1;
      r_mosi   <= 1'b0;
      r_rxWord <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= XFER;
            flag     <= 1'b0;
            r_bitCnt <= '0;
            r_cs     <= w_csSel;
            r_mosi   <= serialBit(bus.masterDataToSend);
          end
        end
        XFER: begin
          r_mosi   <= serialBit(w_txNext);
          r_bitCnt <= r_bitCnt + 3'd1;
          // The eighth sample is folded in here via the post-shift value.
          if (w_last) begin
            r_rxWord <= w_rxNext;
            r_state  <= IDLE;
            flag     <= 1'b1;
            r_cs     <= '1;
            r_mosi   <= 1'b0;
            r_bitCnt <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          flag    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.SCLK               = ~clk & ~flag;
  assign bus.CS                 = r_cs;
  assign bus.MOSI               = r_mosi;
  assign bus.masterDataReceived = r_rxWord;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module  : tb_spi_master
// Brief   : Directed bench for spi_master with a slave model and tx/rx
//           scoreboard queues.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;
  import spi_master_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] expRxQ[$];
  logic [7:0] expTxQ[$];

  always #5 clk = ~clk;

  spi_master_if bus ();

  spi_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bitPos(input int i);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return 7 - i;
`else
    return i;
`endif
  endfunction

  // One full transfer; midStartAt >= 0 re-pulses start just before T(midStartAt+1).
  task automatic runXfer(input logic [1:0] ss, input logic [7:0] txW, input logic [7:0] rxW,
                         input int midStartAt, input logic [2:0] expCs);
    logic [7:0] got;
    logic [7:0] expW;
    got = '0;
    @(negedge clk);
    bus.start            = 1'b1;
    bus.slaveSelect      = ss;
    bus.masterDataToSend = txW;
    bus.MISO             = rxW[bitPos(0)];
    expTxQ.push_back(txW);
    expRxQ.push_back(rxW);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got[bitPos(i)] = bus.MOSI;
      check("cs_during_xfer", {29'b0, bus.CS}, {29'b0, expCs});
      check("sclk_high_midbit", {31'b0, bus.SCLK}, 32'd1);
      if (i > 0) bus.MISO = rxW[bitPos(i)];
      if (i == midStartAt) begin
        bus.start            = 1'b1;
        bus.masterDataToSend = ~txW;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    bus.MISO = 1'b0;
    check("flag_after_T8", {31'b0, dut.flag}, 32'd1);
    check("cs_after_T8", {29'b0, bus.CS}, 32'h7);
    expW = expRxQ.pop_front();
    check("rx_word", {24'b0, bus.masterDataReceived}, {24'b0, expW});
    expW = expTxQ.pop_front();
    check("tx_word", {24'b0, got}, {24'b0, expW});
  endtask

  initial begin
    bus.start            = 1'b0;
    bus.slaveSelect      = 2'd0;
    bus.masterDataToSend = 8'h00;
    bus.MISO             = 1'b0;

    // Reset held for one edge.
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_cs", {29'b0, bus.CS}, 32'h7);
    check("rst_sclk", {31'b0, bus.SCLK}, 32'd0);
    check("rst_mosi", {31'b0, bus.MOSI}, 32'd0);
    check("rst_rx", {24'b0, bus.masterDataReceived}, 32'd0);
    check("rst_flag", {31'b0, dut.flag}, 32'd1);

    runXfer(2'd1, 8'b01010011, 8'b00001001, -1, 3'b101);

    runXfer(2'd0, 8'b00111100, 8'b10011000, -1, 3'b011);
    runXfer(2'd2, 8'b01010101, 8'b11111111, -1, 3'b110);
    runXfer(2'd1, 8'b01011111, 8'b10011000, -1, 3'b101);

    // start re-pulsed at T3 must be ignored.
    runXfer(2'd2, 8'hA5, 8'h3C, 2, 3'b110);

    // Reset asserted at T4 aborts the transfer.
    @(negedge clk);
    bus.start            = 1'b1;
    bus.slaveSelect      = 2'd0;
    bus.masterDataToSend = 8'hF0;
    bus.MISO             = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_abort_flag", {31'b0, dut.flag}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs", {29'b0, bus.CS}, 32'h7);
    check("abort_flag", {31'b0, dut.flag}, 32'd1);
    check("abort_rx", {24'b0, bus.masterDataReceived}, 32'd0);
    check("abort_mosi", {31'b0, bus.MOSI}, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    bus.MISO = 1'b0;

    runXfer(2'd0, 8'h81, 8'h7E, -1, 3'b011);

    // slaveSelect=3 selects nobody.
    @(negedge clk);
    bus.start            = 1'b1;
    bus.slaveSelect      = 2'd3;
    bus.masterDataToSend = 8'hFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("sel3_flag", {31'b0, dut.flag}, 32'd1);
    check("sel3_cs", {29'b0, bus.CS}, 32'h7);
    @(negedge clk);
    check("sel3_sclk", {31'b0, bus.SCLK}, 32'd0);
    check("sel3_rx_held", {24'b0, bus.masterDataReceived}, 32'h7E);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
